regblock_csr: RTL and testbench
===============================

REGBLOCK_CSR -- requirements
Module: regblock_csr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning CPU byte-address width; the register map decodes only addresses 0x00-0x10.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port cpuif_req, input, 1 bit: single-cycle access request.
REQ-005 SHALL have port cpuif_req_is_wr, input, 1 bit: 1=write, 0=read.
REQ-006 SHALL have port cpuif_addr, input, ADDR_WIDTH bits: byte address, word aligned.
REQ-007 SHALL have port cpuif_wr_data, input, 32 bits: write data.
REQ-008 SHALL have port cpuif_wr_biten, input, 32 bits: per-bit write enable.
REQ-009 SHALL have port cpuif_ack, output, 1 bit: access-complete pulse.
REQ-010 SHALL have port cpuif_rd_data, output, 32 bits: read data, valid with ack.
REQ-011 SHALL have port cpuif_err, output, 1 bit: access error, valid with ack.
REQ-012 SHALL have port hwif_in_status, input, 8 bits: hardware status value.
REQ-013 SHALL have port hwif_in_cnt_incr, input, 1 bit: counter increment pulse.
REQ-014 SHALL have port hwif_in_irq_set, input, 4 bits: event pulses.
REQ-015 SHALL have port hwif_out_ctrl_en, output, 1 bit: CTRL.EN.
REQ-016 SHALL have port hwif_out_ctrl_mode, output, 3 bits: CTRL.MODE.
REQ-017 SHALL have port hwif_out_scratch, output, 32 bits: SCRATCH value.
REQ-018 SHALL have port hwif_out_irq, output, 1 bit: OR of IRQ bits masked by CTRL.IE.

Function
REQ-019 SHALL implement this register map:
- 0x00 CTRL: RW; EN[0], MODE[3:1], IE[7:4]; other bits read 0.
- 0x04 STATUS: RO; [7:0]=hwif_in_status; writes ignored without error.
- 0x08 COUNT: [15:0]; +1 per cycle with cnt_incr high, wraps 0xFFFF->0; a write with any biten set in [15:0] loads (old & ~biten)|(wr_data & biten) and takes priority over the increment that cycle.
- 0x0C SCRATCH: RW, 32 bits.
- 0x10 IRQ: [3:0] sticky, W1C; a set pulse wins over a simultaneous clear of the same bit.
REQ-020 SHALL apply RW writes only to bits with wr_biten=1.
REQ-021 SHALL assert cpuif_ack for exactly one cycle, the cycle after cpuif_req is sampled high; accesses can be issued back-to-back.
REQ-022 SHALL return rd_data=0 and err=1 with ack for unmapped or unaligned addresses; write state is unchanged.
REQ-023 SHALL hold rd_data at 0 whenever ack is low.
REQ-024 SHALL take reads of STATUS/COUNT/IRQ from the value registered at the request edge; that value excludes same-cycle hardware updates.
REQ-025 SHALL register hwif_out_* directly from the register state; hwif_out_irq = |(IRQ & IE).
REQ-026 SHALL keep every output free of X/Z from the first clock after reset is released.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear CTRL, COUNT, SCRATCH and IRQ, and drive cpuif_ack=0, cpuif_err=0, cpuif_rd_data=0 and all hwif_out_* to 0.
REQ-028 SHALL, when reset arrives during an access, abort that access with no ack.

Verification
REQ-029 Reset, then read 0x00, 0x08, 0x0C -> each acks one cycle later with rd_data 0, err 0; all hwif_out 0.
REQ-030 Write 0x0C=0xDEADBEEF with biten 0xFFFF0000 -> hwif_out_scratch=0xDEAD0000; readback matches.
REQ-031 Write COUNT=0xFFFE, then three cnt_incr pulses -> read returns 0x0001.
REQ-032 Pulse irq_set=0b0101, CTRL.IE=0xF -> hwif_out_irq=1; write 0x10=0b0001 -> IRQ reads 0b0100, irq stays 1; write 0b0100 -> irq=0.
REQ-033 Read 0x14 and 0x02 -> ack with err=1, rd_data=0.
REQ-034 Issue a write to CTRL=0x3 back-to-back with a read of CTRL -> the read returns 0x3; hwif_out_ctrl_en=1, ctrl_mode=1.

Source files
------------

// File: rtl/regblock_csr.sv
// CSR block: CTRL / STATUS / COUNT / SCRATCH / IRQ behind a single-cycle CPU port.
// Every access acks one cycle after the request; read data is zero whenever ack is low.
module regblock_csr #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpuif_req,
  input  logic                  cpuif_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] cpuif_addr,
  input  logic [31:0]           cpuif_wr_data,
  input  logic [31:0]           cpuif_wr_biten,
  output logic                  cpuif_ack,
  output logic [31:0]           cpuif_rd_data,
  output logic                  cpuif_err,
  input  logic [7:0]            hwif_in_status,
  input  logic                  hwif_in_cnt_incr,
  input  logic [3:0]            hwif_in_irq_set,
  output logic                  hwif_out_ctrl_en,
  output logic [2:0]            hwif_out_ctrl_mode,
  output logic [31:0]           hwif_out_scratch,
  output logic                  hwif_out_irq
);

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] rd_data;
  } resp_t;

  localparam logic [31:0] A_CTRL    = 32'h00;
  localparam logic [31:0] A_STATUS  = 32'h04;
  localparam logic [31:0] A_COUNT   = 32'h08;
  localparam logic [31:0] A_SCRATCH = 32'h0C;
  localparam logic [31:0] A_IRQ     = 32'h10;

  logic [7:0]  ctrl_q,    ctrl_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [31:0] scratch_q, scratch_d;
  logic [3:0]  irq_q,     irq_d;
  resp_t       resp_q,    resp_d;

  logic [31:0] addr;
  logic        sel_ctrl, sel_status, sel_cnt, sel_scratch, sel_irq, mapped;
  logic        wr, rd;

  assign addr        = 32'(cpuif_addr);
  assign sel_ctrl    = (addr == A_CTRL);
  assign sel_status  = (addr == A_STATUS);
  assign sel_cnt     = (addr == A_COUNT);
  assign sel_scratch = (addr == A_SCRATCH);
  assign sel_irq     = (addr == A_IRQ);
  // Exact-match decode, so unaligned offsets fall out as unmapped.
  assign mapped      = sel_ctrl | sel_status | sel_cnt | sel_scratch | sel_irq;
  assign wr          = cpuif_req & cpuif_req_is_wr & mapped;
  assign rd          = cpuif_req & ~cpuif_req_is_wr & mapped;

  always_comb begin
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q + {15'd0, hwif_in_cnt_incr};
    scratch_d = scratch_q;
    irq_d     = irq_q;

    if (wr && sel_ctrl)
      ctrl_d = (ctrl_q & ~cpuif_wr_biten[7:0]) | (cpuif_wr_data[7:0] & cpuif_wr_biten[7:0]);
    // A software load beats the hardware increment in the same cycle.
    if (wr && sel_cnt && (|cpuif_wr_biten[15:0]))
      cnt_d = (cnt_q & ~cpuif_wr_biten[15:0]) | (cpuif_wr_data[15:0] & cpuif_wr_biten[15:0]);
    if (wr && sel_scratch)
      scratch_d = (scratch_q & ~cpuif_wr_biten) | (cpuif_wr_data & cpuif_wr_biten);
    if (wr && sel_irq)
      irq_d = irq_q & ~(cpuif_wr_data[3:0] & cpuif_wr_biten[3:0]);
    // Set is applied after clear so a coincident event is never lost.
    irq_d = irq_d | hwif_in_irq_set;
  end

  always_comb begin
    resp_d         = '0;
    resp_d.ack     = cpuif_req;
    resp_d.err     = cpuif_req & ~mapped;
    if (rd) begin
      unique case (1'b1)
        sel_ctrl:    resp_d.rd_data = {24'd0, ctrl_q};
        sel_status:  resp_d.rd_data = {24'd0, hwif_in_status};
        sel_cnt:     resp_d.rd_data = {16'd0, cnt_q};
        sel_scratch: resp_d.rd_data = scratch_q;
        sel_irq:     resp_d.rd_data = {28'd0, irq_q};
        default:     resp_d.rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= '0;
      cnt_q     <= '0;
      scratch_q <= '0;
      irq_q     <= '0;
      resp_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      irq_q     <= irq_d;
      resp_q    <= resp_d;
    end
  end

  assign cpuif_ack          = resp_q.ack;
  assign cpuif_err          = resp_q.err;
  assign cpuif_rd_data      = resp_q.rd_data;
  assign hwif_out_ctrl_en   = ctrl_q[0];
  assign hwif_out_ctrl_mode = ctrl_q[3:1];
  assign hwif_out_scratch   = scratch_q;
  assign hwif_out_irq       = |(irq_q & ctrl_q[7:4]);

endmodule

// File: tb/tb_regblock_csr.sv
// Bench for regblock_csr: directed register-map scenarios then random traffic,
// all checked against a register-level reference model.
module tb_regblock_csr;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpuif_req, cpuif_req_is_wr;
  logic [AW-1:0] cpuif_addr;
  logic [31:0]   cpuif_wr_data, cpuif_wr_biten;
  logic          cpuif_ack, cpuif_err;
  logic [31:0]   cpuif_rd_data;
  logic [7:0]    hwif_in_status;
  logic          hwif_in_cnt_incr;
  logic [3:0]    hwif_in_irq_set;
  logic          hwif_out_ctrl_en;
  logic [2:0]    hwif_out_ctrl_mode;
  logic [31:0]   hwif_out_scratch;
  logic          hwif_out_irq;

  always #5 clk = ~clk;

  regblock_csr #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
    .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_ack(cpuif_ack), .cpuif_rd_data(cpuif_rd_data), .cpuif_err(cpuif_err),
    .hwif_in_status(hwif_in_status), .hwif_in_cnt_incr(hwif_in_cnt_incr),
    .hwif_in_irq_set(hwif_in_irq_set),
    .hwif_out_ctrl_en(hwif_out_ctrl_en), .hwif_out_ctrl_mode(hwif_out_ctrl_mode),
    .hwif_out_scratch(hwif_out_scratch), .hwif_out_irq(hwif_out_irq)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: register contents plus the expected response of the last access.
  logic [7:0]  m_ctrl;
  logic [15:0] m_cnt;
  logic [31:0] m_scr;
  logic [3:0]  m_irq;
  logic        e_ack, e_err;
  logic [31:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] b);
    return (old & ~b) | (d & b);
  endfunction

  // Inputs are already driven (at negedge); advance one clock, update the model, check.
  task automatic step();
    int  a;
    logic [31:0] nc;
    a = int'(cpuif_addr);
    if (!rst) begin
      m_ctrl = 0; m_cnt = 0; m_scr = 0; m_irq = 0;
      e_ack = 0; e_err = 0; e_rd = 0;
    end else begin
      bit ok;
      ok    = (a == 0) || (a == 4) || (a == 8) || (a == 12) || (a == 16);
      e_ack = cpuif_req;
      e_err = cpuif_req && !ok;
      e_rd  = 0;
      if (cpuif_req && !cpuif_req_is_wr && ok) begin
        case (a)
          0:  e_rd = {24'd0, m_ctrl};
          4:  e_rd = {24'd0, hwif_in_status};
          8:  e_rd = {16'd0, m_cnt};
          12: e_rd = m_scr;
          default: e_rd = {28'd0, m_irq};
        endcase
      end
      nc = (32'(m_cnt) + (hwif_in_cnt_incr ? 1 : 0)) % 65536;
      if (cpuif_req && cpuif_req_is_wr && ok) begin
        case (a)
          0:  m_ctrl = 8'(wmask({24'd0, m_ctrl}, cpuif_wr_data, cpuif_wr_biten));
          8:  if (cpuif_wr_biten[15:0] != 0)
                nc = wmask({16'd0, m_cnt}, cpuif_wr_data, {16'd0, cpuif_wr_biten[15:0]});
          12: m_scr = wmask(m_scr, cpuif_wr_data, cpuif_wr_biten);
          16: m_irq = m_irq & ~(cpuif_wr_data[3:0] & cpuif_wr_biten[3:0]);
          default: ;
        endcase
      end
      m_cnt = nc[15:0];
      m_irq = m_irq | hwif_in_irq_set;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ack", {31'd0, cpuif_ack}, {31'd0, e_ack});
    chk("err", {31'd0, cpuif_err}, {31'd0, e_err});
    chk("rd_data", cpuif_rd_data, e_rd);
    chk("ctrl_en", {31'd0, hwif_out_ctrl_en}, {31'd0, m_ctrl[0]});
    chk("ctrl_mode", {29'd0, hwif_out_ctrl_mode}, {29'd0, m_ctrl[3:1]});
    chk("scratch", hwif_out_scratch, m_scr);
    chk("irq", {31'd0, hwif_out_irq}, {31'd0, |(m_irq & m_ctrl[7:4])});
  endtask

  task automatic acc(input bit w, input int a, input logic [31:0] d, input logic [31:0] b);
    cpuif_req = 1; cpuif_req_is_wr = w; cpuif_addr = AW'(a);
    cpuif_wr_data = d; cpuif_wr_biten = b;
    step();
    cpuif_req = 0;
  endtask

  task automatic idle(input int n);
    cpuif_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int alist[9];
    alist = '{0, 4, 8, 12, 16, 20, 2, 31, 0};
    rst = 0; cpuif_req = 0; cpuif_req_is_wr = 0; cpuif_addr = 0;
    cpuif_wr_data = 0; cpuif_wr_biten = 0;
    hwif_in_status = 8'h5A; hwif_in_cnt_incr = 0; hwif_in_irq_set = 0;
    @(negedge clk);
    idle(3);
    chk("rst_ack", {31'd0, cpuif_ack}, 32'd0);
    chk("rst_scratch", hwif_out_scratch, 32'd0);
    rst = 1;

    // Reads right after reset return zero without error.
    acc(0, 8'h00, 0, 0); chk("r0_rd", cpuif_rd_data, 0); chk("r0_ack", {31'd0, cpuif_ack}, 1);
    acc(0, 8'h08, 0, 0); chk("r8_rd", cpuif_rd_data, 0);
    acc(0, 8'h0C, 0, 0); chk("rC_rd", cpuif_rd_data, 0); chk("rC_err", {31'd0, cpuif_err}, 0);
    idle(1); chk("ack_pulse", {31'd0, cpuif_ack}, 0);

    // Partial-bit write to SCRATCH.
    acc(1, 8'h0C, 32'hDEADBEEF, 32'hFFFF0000);
    chk("scr_out", hwif_out_scratch, 32'hDEAD0000);
    acc(0, 8'h0C, 0, 0); chk("scr_rd", cpuif_rd_data, 32'hDEAD0000);

    // COUNT wrap.
    acc(1, 8'h08, 32'h0000FFFE, 32'h0000FFFF);
    hwif_in_cnt_incr = 1; idle(3); hwif_in_cnt_incr = 0;
    acc(0, 8'h08, 0, 0); chk("cnt_wrap", cpuif_rd_data, 32'h1);

    // STATUS reads the hardware value; writes are ignored without error.
    acc(1, 8'h04, 32'hFFFFFFFF, 32'hFFFFFFFF); chk("st_wr_err", {31'd0, cpuif_err}, 0);
    acc(0, 8'h04, 0, 0); chk("st_rd", cpuif_rd_data, 32'h5A);

    // IRQ sticky / W1C / masking.
    acc(1, 8'h00, 32'hF0, 32'hFF);
    hwif_in_irq_set = 4'b0101; idle(1); hwif_in_irq_set = 0;
    chk("irq_set", {31'd0, hwif_out_irq}, 1);
    acc(1, 8'h10, 32'h1, 32'hF);
    acc(0, 8'h10, 0, 0); chk("irq_rd", cpuif_rd_data, 32'h4);
    chk("irq_still", {31'd0, hwif_out_irq}, 1);
    acc(1, 8'h10, 32'h4, 32'hF); chk("irq_clr", {31'd0, hwif_out_irq}, 0);
    // Set wins over a simultaneous clear of the same bit.
    hwif_in_irq_set = 4'b0010; acc(1, 8'h10, 32'h2, 32'hF); hwif_in_irq_set = 0;
    acc(0, 8'h10, 0, 0); chk("irq_setwin", cpuif_rd_data, 32'h2);

    // Unmapped / unaligned.
    acc(0, 8'h14, 0, 0); chk("u14_err", {31'd0, cpuif_err}, 1); chk("u14_rd", cpuif_rd_data, 0);
    acc(0, 8'h02, 0, 0); chk("u02_err", {31'd0, cpuif_err}, 1); chk("u02_rd", cpuif_rd_data, 0);

    // Back-to-back write then read of CTRL.
    acc(1, 8'h00, 32'h3, 32'hFFFFFFFF);
    acc(0, 8'h00, 0, 0);
    chk("b2b_rd", cpuif_rd_data, 32'h3);
    chk("b2b_en", {31'd0, hwif_out_ctrl_en}, 1);
    chk("b2b_mode", {29'd0, hwif_out_ctrl_mode}, 1);

    // Reset arriving with a request aborts it.
    cpuif_req = 1; cpuif_req_is_wr = 0; cpuif_addr = 0; rst = 0;
    step(); chk("abort_ack", {31'd0, cpuif_ack}, 0);
    cpuif_req = 0; rst = 1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) != 0);
      cpuif_req        = $urandom_range(0, 2) != 0;
      cpuif_req_is_wr  = $urandom_range(0, 1) != 0;
      cpuif_addr       = AW'(($urandom_range(0, 8) == 8) ? $urandom_range(0, 31)
                                                         : alist[$urandom_range(0, 7)]);
      cpuif_wr_data    = $urandom;
      cpuif_wr_biten   = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom;
      hwif_in_status   = 8'($urandom);
      hwif_in_cnt_incr = $urandom_range(0, 1) != 0;
      hwif_in_irq_set  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
